sha_cmd_responder: RTL and testbench

- Responder end of the SHA control-FSM command/ACK protocol; it sits on the data bus on the memory/accelerator side.
- Samples command bytes driven by the initiator on the bus, decodes them, and models each operation's completion with a programmable latency.
- Returns a one-cycle pulse on the matching ack line.
- Also reports busy status, bad opcodes and a count of dropped commands.

---
 rtl/sha_bus_pkg.sv | 59 +++++
 rtl/sha_resp_lat_cnt.sv | 42 ++++
 rtl/sha_cmd_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_sha_cmd_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha_bus_pkg
// Purpose  : Types and constants shared by both ends of the SHA command/ACK
//            bus (initiator FSM and responder). It holds the opcode bytes,
//            the ack line indices, the responder state encoding and an
//            opcode decoder.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package sha_bus_pkg;

  // Command bytes driven by the initiator
  localparam logic [7:0] OP_RDKEY = 8'hA1;
  localparam logic [7:0] OP_RDTXT = 8'hB2;
  localparam logic [7:0] OP_HASH  = 8'hC3;
  localparam logic [7:0] OP_WRITE = 8'hD4;

  // Bit positions on the 3-bit ack bus
  localparam int ACK_RD   = 0;
  localparam int ACK_TXT  = 1;
  localparam int ACK_HASH = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_EXEC    = 2'd2,
    ST_ACK     = 2'd3
  } resp_state_t;

  // Which programmable latency an opcode uses
  typedef enum logic [1:0] {
    LAT_NONE = 2'd0,
    LAT_RD   = 2'd1,
    LAT_HASH = 2'd2,
    LAT_WR   = 2'd3
  } lat_sel_t;

  typedef struct packed {
    logic       ok;       // opcode is known
    logic [1:0] ack_idx;  // ack line to pulse on completion
    lat_sel_t   lat;      // latency class
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [7:0] op);
    op_dec_t d;
    d = '{ok: 1'b0, ack_idx: 2'd0, lat: LAT_NONE};
    case (op)
      OP_RDKEY: d = '{ok: 1'b1, ack_idx: 2'(ACK_RD),   lat: LAT_RD};
      OP_RDTXT: d = '{ok: 1'b1, ack_idx: 2'(ACK_TXT),  lat: LAT_RD};
      OP_HASH:  d = '{ok: 1'b1, ack_idx: 2'(ACK_HASH), lat: LAT_HASH};
      OP_WRITE: d = '{ok: 1'b1, ack_idx: 2'(ACK_RD),   lat: LAT_WR};
      default:  d = '{ok: 1'b0, ack_idx: 2'd0,         lat: LAT_NONE};
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha_resp_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : sha_resp_lat_cnt
// Purpose  : Loadable down-counter that models the operation latency of the
//            responder. Load has priority over decrement. The counter holds
//            at zero.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            load,load_val - load a new count
//            dec           - decrement by one this cycle
//            zero          - count is zero
//            last          - count is one (the next decrement reaches zero)
// Revision : 1.0  initial release
// ============================================================================
module sha_resp_lat_cnt #(
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [CNTW-1:0] load_val,
  input  logic            dec,
  output logic            zero,
  output logic            last
);

  logic [CNTW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);
  assign last = (r_count == CNTW'(1));

endmodule
`default_nettype wire

// File: rtl/sha_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : sha_cmd_responder
// Purpose  : Responder end of the SHA command/ACK bus. It samples a command
//            byte, decodes it, waits a programmable latency and then pulses
//            the matching ack line for one cycle. It also reports busy, bad
//            opcodes and a saturating count of dropped commands.
// Ports    : clk, rst   - clock, asynchronous active-high reset
//            bus_valid  - command present on the bus
//            bus_data   - command byte (DATA_LAG cycles after bus_valid)
//            ack_out    - [0] key read/write, [1] text read, [2] hash done
//            busy       - responder is not idle
//            err_op     - one-cycle pulse on an unknown opcode
//            drop_cnt   - saturating count of dropped commands
// Config   : define SHA_RESP_PENDING_EN to add a one-entry pending slot for
//            the first command that arrives while busy
// Revision : 1.0  initial release
// ============================================================================
module sha_cmd_responder #(
  parameter int RD_LAT   = 4,
  parameter int HASH_LAT = 16,
  parameter int WR_LAT   = 4,
  parameter int CNTW     = 8,
  parameter int DATA_LAG = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_valid,
  input  logic [7:0] bus_data,
  output logic [2:0] ack_out,
  output logic       busy,
  output logic       err_op,
  output logic [7:0] drop_cnt
);
  import sha_bus_pkg::*;

  // The counter is loaded with LAT-1. A load of zero (LAT=1) goes straight
  // to ACK. The registered ack then appears exactly LAT edges after decode.
  localparam logic [CNTW-1:0] c_rd_ld   = CNTW'(RD_LAT - 1);
  localparam logic [CNTW-1:0] c_hash_ld = CNTW'(HASH_LAT - 1);
  localparam logic [CNTW-1:0] c_wr_ld   = CNTW'(WR_LAT - 1);

  function automatic logic [CNTW-1:0] lat_load(input lat_sel_t sel);
    case (sel)
      LAT_RD:   return c_rd_ld;
      LAT_HASH: return c_hash_ld;
      LAT_WR:   return c_wr_ld;
      default:  return '0;
    endcase
  endfunction

  resp_state_t     r_state;
  resp_state_t     w_state_nxt;
  logic [1:0]      r_tgt;
  logic [1:0]      w_tgt_nxt;
  logic            w_cnt_load;
  logic [CNTW-1:0] w_cnt_val;
  logic            w_cnt_dec;
  logic            w_cnt_zero;
  logic            w_cnt_last;
  logic            w_launch;
  logic            w_do_dec;
  logic [7:0]      w_dec_byte;
  op_dec_t         w_dec;
  logic [2:0]      w_ack_nxt;
  logic            w_err_nxt;
  logic            w_drop;

`ifdef SHA_RESP_PENDING_EN
  logic       r_pend_vld;   // slot holds a captured opcode
  logic       r_pend_wait;  // bus_valid seen, byte arrives this cycle
  logic [7:0] r_pend_op;
  logic       r_err_defer;  // bad queued opcode, reported after the ack
  logic       w_pend_vld_nxt;
  logic       w_pend_wait_nxt;
  logic [7:0] w_pend_op_nxt;
  logic       w_err_defer_nxt;
  logic       w_slot_full;
`endif

  sha_resp_lat_cnt #(
    .CNTW (CNTW)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_cnt_load),
    .load_val (w_cnt_val),
    .dec      (w_cnt_dec),
    .zero     (w_cnt_zero),
    .last     (w_cnt_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt;
    w_cnt_load  = 1'b0;
    w_cnt_val   = '0;
    w_cnt_dec   = 1'b0;
    w_launch    = 1'b0;
    w_do_dec    = 1'b0;
    w_dec_byte  = bus_data;
    w_ack_nxt   = 3'b000;
    w_err_nxt   = 1'b0;
    w_drop      = 1'b0;
`ifdef SHA_RESP_PENDING_EN
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_wait_nxt = 1'b0;
    w_pend_op_nxt   = r_pend_op;
    w_err_defer_nxt = 1'b0;
    w_err_nxt       = r_err_defer;
    w_slot_full     = r_pend_vld | r_pend_wait;
`endif

    case (r_state)
      ST_IDLE:    w_launch = 1'b1;
      ST_CAPTURE: w_do_dec = 1'b1;
      ST_EXEC: begin
        w_cnt_dec = 1'b1;
        // zero only guards against a counter that was never loaded
        if (w_cnt_last || w_cnt_zero) begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        w_ack_nxt   = 3'b001 << r_tgt;
        w_state_nxt = ST_IDLE;
`ifdef SHA_RESP_PENDING_EN
        w_launch    = 1'b1;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase

`ifdef SHA_RESP_PENDING_EN
    // A command that contends with an in-flight or queued one either fills
    // the empty slot or is dropped.
    if (r_pend_wait) begin
      w_pend_vld_nxt = 1'b1;
      w_pend_op_nxt  = bus_data;
    end
    if (bus_valid && ((r_state != ST_IDLE) || w_slot_full)) begin
      if (w_slot_full) begin
        w_drop = 1'b1;
      end else if (DATA_LAG != 0) begin
        w_pend_wait_nxt = 1'b1;
      end else begin
        w_pend_vld_nxt = 1'b1;
        w_pend_op_nxt  = bus_data;
      end
    end
`else
    w_drop = bus_valid && (r_state != ST_IDLE);
`endif

    // Start a new command: the queued opcode takes priority over the bus
    if (w_launch) begin
`ifdef SHA_RESP_PENDING_EN
      if (r_pend_vld) begin
        w_do_dec   = 1'b1;
        w_dec_byte = r_pend_op;
      end else if (r_pend_wait) begin
        w_do_dec   = 1'b1;
      end else
`endif
      if (bus_valid) begin
        if (DATA_LAG != 0) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_do_dec = 1'b1;
        end
      end
`ifdef SHA_RESP_PENDING_EN
      // Everything in the slot (or arriving now) is consumed by the launch
      w_pend_vld_nxt  = 1'b0;
      w_pend_wait_nxt = 1'b0;
`endif
    end

    w_dec = decode_op(w_dec_byte);
    if (w_do_dec) begin
      if (w_dec.ok) begin
        w_tgt_nxt   = w_dec.ack_idx;
        w_cnt_load  = 1'b1;
        w_cnt_val   = lat_load(w_dec.lat);
        w_state_nxt = (w_cnt_val == '0) ? ST_ACK : ST_EXEC;
      end else begin
        w_state_nxt = ST_IDLE;
`ifdef SHA_RESP_PENDING_EN
        // err_op must not share a cycle with the ack being emitted now
        if (r_state == ST_ACK) begin
          w_err_defer_nxt = 1'b1;
        end else begin
          w_err_nxt = 1'b1;
        end
`else
        w_err_nxt = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_tgt    <= 2'd0;
      ack_out  <= 3'b000;
      err_op   <= 1'b0;
      busy     <= 1'b0;
      drop_cnt <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_tgt    <= w_tgt_nxt;
      ack_out  <= w_ack_nxt;
      err_op   <= w_err_nxt;
      busy     <= (w_state_nxt != ST_IDLE);
      if (w_drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

`ifdef SHA_RESP_PENDING_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_vld  <= 1'b0;
      r_pend_wait <= 1'b0;
      r_pend_op   <= 8'h00;
      r_err_defer <= 1'b0;
    end else begin
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_wait <= w_pend_wait_nxt;
      r_pend_op   <= w_pend_op_nxt;
      r_err_defer <= w_err_defer_nxt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha_cmd_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sha_cmd_responder
// Purpose  : Scoreboard bench for sha_cmd_responder with default parameters.
//            Stimulus pushes expected ack/err events (value and edge index),
//            and a monitor pops and compares them whenever the DUT pulses.
// Revision : 1.0  initial release
// ============================================================================
module tb_sha_cmd_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bus_valid = 1'b0;
  logic [7:0] bus_data = 8'h00;
  logic [2:0] ack_out;
  logic       busy;
  logic       err_op;
  logic [7:0] drop_cnt;

  typedef struct {
    logic [2:0] ack;
    logic       err;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  int  tests    = 0;
  int  failed   = 0;
  int  cyc      = 0;
  int  exp_drop = 0;

  sha_cmd_responder dut (
    .clk       (clk),
    .rst       (rst),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .ack_out   (ack_out),
    .busy      (busy),
    .err_op    (err_op),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack or err pulse must match the head of the queue
  always @(negedge clk) begin
    if (!rst && ((ack_out != 3'b000) || err_op)) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_event: ack_out=%b err_op=%b cyc=%0d, none expected", ack_out, err_op, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (ack_out !== e.ack || err_op !== e.err || cyc != e.cyc) begin
          failed++;
          $display("FAIL event: ack_out=%b err_op=%b cyc=%0d, expected ack_out=%b err_op=%b cyc=%0d",
                   ack_out, err_op, cyc, e.ack, e.err, e.cyc);
        end
      end
    end
  end

  // Called at a negedge: bus_valid for one cycle, then the byte one cycle later.
  // e0 is the index of the edge that samples bus_valid.
  task automatic drive(input logic [7:0] op, output int e0);
    bus_valid = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    bus_valid = 1'b0;
    bus_data  = op;
    @(negedge clk);
    bus_data  = 8'h00;
  endtask

  // Issue a command and push its expected pulse: edge e0 + 1 (data lag) + lat
  task automatic send(input logic [7:0] op, input logic [2:0] ack, input logic err,
                      input int lat, output int e0);
    ev_t e;
    drive(op, e0);
    e.ack = ack;
    e.err = err;
    e.cyc = e0 + 1 + lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", busy, 0);
  endtask

  task automatic add_drops(input int n);
    exp_drop = exp_drop + n;
    if (exp_drop > 255) exp_drop = 255;
  endtask

  logic [7:0] seq_op[4]  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [2:0] seq_ack[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  int         seq_lat[4] = '{4, 4, 16, 4};

  initial begin
    int e0;
    ev_t e;

    // Reset state
    #1;
    check("rst_ack_out", ack_out, 0);
    check("rst_busy", busy, 0);
    check("rst_err_op", err_op, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // RDKEY: ack 001 five edges after the valid edge, busy until then
    send(8'hA1, 3'b001, 1'b0, 4, e0);
    while (cyc < e0 + 5) begin
      check("rdkey_busy_high", busy, 1);
      @(negedge clk);
    end
    check("rdkey_busy_low_at_ack", busy, 0);
    check("rdkey_ack_visible", ack_out, 3'b001);
    wait_idle();

    // HASH with a second command arriving during EXEC
    send(8'hC3, 3'b100, 1'b0, 16, e0);
    while (cyc < e0 + 5) @(negedge clk);
    begin
      int e1;
      drive(8'hA1, e1);
    end
`ifdef SHA_RESP_PENDING_EN
    // queued command launches as the hash ack leaves, full RD latency
    e.ack = 3'b001; e.err = 1'b0; e.cyc = e0 + 17 + 4;
    exp_q.push_back(e);
`else
    add_drops(1);
`endif
    wait_idle();
    check("drop_during_exec", drop_cnt, exp_drop);

    // Unknown opcode: err pulse, no ack, idle again within two cycles
    send(8'h55, 3'b000, 1'b1, 0, e0);
    check("badop_busy_low", busy, 0);
    @(negedge clk);
    check("badop_err_cleared", err_op, 0);
    wait_idle();

    // Full sequence, each issued after the previous ack
    for (int i = 0; i < 4; i++) begin
      wait_idle();
      send(seq_op[i], seq_ack[i], 1'b0, seq_lat[i], e0);
    end
    wait_idle();
    check("seq_drop_cnt", drop_cnt, exp_drop);

    // Reset in the middle of a WRITE: outputs clear at once, ack never comes
    drive(8'hD4, e0);
    while (cyc < e0 + 3) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_ack_out", ack_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err_op", err_op, 0);
    check("midrst_drop_cnt", drop_cnt, 0);
    exp_drop = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_busy", busy, 0);

    // Drop saturation: 25 hashes, bus_valid held for 12 busy edges each
    for (int r = 0; r < 25; r++) begin
      wait_idle();
      send(8'hC3, 3'b100, 1'b0, 16, e0);
      bus_valid = 1'b1;
      bus_data  = 8'hA1;
      repeat (12) @(negedge clk);
      bus_valid = 1'b0;
      bus_data  = 8'h00;
`ifdef SHA_RESP_PENDING_EN
      e.ack = 3'b001; e.err = 1'b0; e.cyc = e0 + 17 + 4;
      exp_q.push_back(e);
      add_drops(11);
`else
      add_drops(12);
`endif
      wait_idle();
      check("sat_drop_cnt", drop_cnt, exp_drop);
    end
    check("sat_final", drop_cnt, 8'hFF);

    repeat (8) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
